// File: rtl/reorder_queue_drain.sv
`default_nettype none
// ============================================================================
// Module   : reorder_queue_drain
// Purpose  : Tag-indexed reorder buffer for out-of-order response return.
//            A producer writes entries into slots addressed by tag. Consumers
//            either look up and release slots by tag (random-access port) or
//            take entries in strict tag order through a valid/ready drain
//            port that walks a head pointer and never skips a slot.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            enq_valid/ready/data/tag - enqueue into slot enq_tag when free
//            deq_valid/tag         - release of slot deq_tag
//            deq_data/deq_matches  - combinational lookup of slot deq_tag
//            drain_valid/ready/data/tag - in-order drain at the head pointer
//            count/full/empty      - occupancy of the buffer
//            deq_miss              - one-cycle pulse: last release hit a free
//                                    slot
// Revision : 1.0 - initial release
// ============================================================================
module reorder_queue_drain #(
  parameter int DATA_W = 1,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              enq_ready,
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [TAG_W-1:0]  enq_tag,
  input  logic              deq_valid,
  input  logic [TAG_W-1:0]  deq_tag,
  output logic [DATA_W-1:0] deq_data,
  output logic              deq_matches,
  output logic              drain_valid,
  input  logic              drain_ready,
  output logic [DATA_W-1:0] drain_data,
  output logic [TAG_W-1:0]  drain_tag,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              deq_miss
);

  localparam int             c_DEPTH      = 1 << TAG_W;
  localparam logic [TAG_W:0] c_FULL_COUNT = (TAG_W+1)'(c_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_DEPTH-1:0] occ_q;
  logic [c_DEPTH-1:0] occ_d;
  logic [DATA_W-1:0]  data_q [c_DEPTH];
  logic [TAG_W-1:0]   head_q;
  logic [TAG_W-1:0]   head_d;
  logic [TAG_W:0]     count_q;
  logic [TAG_W:0]     count_d;
  logic               deq_miss_q;
  logic               deq_miss_d;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic               w_enq_fire;
  logic               w_drain_fire;
  logic [c_DEPTH-1:0] w_enq_hit;   // slot written this cycle
  logic [c_DEPTH-1:0] w_rel;       // slot released (deq or drain) this cycle
  logic               w_inc;
  logic               w_dec_deq;
  logic               w_dec_drain;

  assign enq_ready    = ~occ_q[enq_tag];
  assign w_enq_fire   = enq_valid & enq_ready;
  assign drain_valid  = occ_q[head_q];
  assign w_drain_fire = drain_valid & drain_ready;

  // Per-slot occupancy update. Release is applied after the set so that an
  // enqueue racing a release of the same slot leaves the slot free.
  for (genvar i = 0; i < c_DEPTH; i++) begin : g_slot
    assign w_enq_hit[i] = w_enq_fire && (enq_tag == TAG_W'(i));
    assign w_rel[i]     = (deq_valid && (deq_tag == TAG_W'(i))) ||
                          (w_drain_fire && (head_q == TAG_W'(i)));
    assign occ_d[i]     = (occ_q[i] | w_enq_hit[i]) & ~w_rel[i];
  end

  // Occupancy delta. An enqueue only counts if its slot is not released in
  // the same cycle. A drain that collides with a deq on the head slot frees
  // that slot only once, so the drain is not counted a second time.
  assign w_inc       = w_enq_fire & ~w_rel[enq_tag];
  assign w_dec_deq   = deq_valid & occ_q[deq_tag];
  assign w_dec_drain = w_drain_fire & ~(deq_valid && (deq_tag == head_q));

  always_comb begin
    head_d     = head_q;
    count_d    = count_q;
    deq_miss_d = deq_valid & ~occ_q[deq_tag];

    if (w_drain_fire) begin
      head_d = head_q + TAG_W'(1);
    end

    count_d = count_q
            + {{TAG_W{1'b0}}, w_inc}
            - {{TAG_W{1'b0}}, w_dec_deq}
            - {{TAG_W{1'b0}}, w_dec_drain};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      head_q     <= '0;
      count_q    <= '0;
      deq_miss_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      count_q    <= count_d;
      deq_miss_q <= deq_miss_d;
    end
  end

  // Payload storage carries no reset; contents are only meaningful while the
  // matching occupied bit is set.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      data_q[enq_tag] <= enq_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign deq_data    = data_q[deq_tag];
  assign deq_matches = occ_q[deq_tag];
  assign drain_data  = data_q[head_q];
  assign drain_tag   = head_q;
  assign count       = count_q;
  assign full        = (count_q == c_FULL_COUNT);
  assign empty       = (count_q == '0);
  assign deq_miss    = deq_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_queue_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_queue_drain
// Purpose  : Self-checking bench for reorder_queue_drain (DATA_W=8, TAG_W=2).
//            Directed scenarios followed by random traffic, all compared each
//            cycle against a slot-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_queue_drain;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enq_ready;
  logic              enq_valid;
  logic [DATA_W-1:0] enq_data;
  logic [TAG_W-1:0]  enq_tag;
  logic              deq_valid;
  logic [TAG_W-1:0]  deq_tag;
  logic [DATA_W-1:0] deq_data;
  logic              deq_matches;
  logic              drain_valid;
  logic              drain_ready;
  logic [DATA_W-1:0] drain_data;
  logic [TAG_W-1:0]  drain_tag;
  logic [TAG_W:0]    count;
  logic              full;
  logic              empty;
  logic              deq_miss;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which slots hold an entry, their payloads, the next
  // slot to drain and whether the previous release found its slot free.
  bit       m_occ  [DEPTH];
  bit [7:0] m_data [DEPTH];
  int       m_head;
  bit       m_miss;

  always #5 clk = ~clk;

  reorder_queue_drain #(
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_ready  (enq_ready),
    .enq_valid  (enq_valid),
    .enq_data   (enq_data),
    .enq_tag    (enq_tag),
    .deq_valid  (deq_valid),
    .deq_tag    (deq_tag),
    .deq_data   (deq_data),
    .deq_matches(deq_matches),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_data (drain_data),
    .drain_tag  (drain_tag),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .deq_miss   (deq_miss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_occ[i];
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_occ[i] = 1'b0;
    m_head = 0;
    m_miss = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output against the model,
  // then advance the model across the clock edge.
  task automatic step(input bit rst, input bit ev, input int et, input bit [7:0] ed,
                      input bit dv, input int dt, input bit dr);
    bit occ_old [DEPTH];
    bit enq_fire;
    bit drain_fire;
    int cnt;
    @(negedge clk);
    reset       = rst;
    enq_valid   = ev;
    enq_tag     = TAG_W'(et);
    enq_data    = ed;
    deq_valid   = dv;
    deq_tag     = TAG_W'(dt);
    drain_ready = dr;
    #1;
    cnt = model_count();
    chk("enq_ready",   32'(enq_ready),   32'(!m_occ[et]));
    chk("deq_matches", 32'(deq_matches), 32'(m_occ[dt]));
    if (m_occ[dt]) chk("deq_data", 32'(deq_data), 32'(m_data[dt]));
    chk("drain_valid", 32'(drain_valid), 32'(m_occ[m_head]));
    if (m_occ[m_head]) chk("drain_data", 32'(drain_data), 32'(m_data[m_head]));
    chk("drain_tag",   32'(drain_tag),   32'(m_head));
    chk("count",       32'(count),       32'(cnt));
    chk("full",        32'(full),        32'(cnt == DEPTH));
    chk("empty",       32'(empty),       32'(cnt == 0));
    chk("deq_miss",    32'(deq_miss),    32'(m_miss));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < DEPTH; i++) occ_old[i] = m_occ[i];
      enq_fire   = ev && !occ_old[et];
      drain_fire = dr && occ_old[m_head];
      if (enq_fire) begin
        m_occ[et]  = 1'b1;
        m_data[et] = ed;
      end
      if (dv) m_occ[dt] = 1'b0;
      if (drain_fire) begin
        m_occ[m_head] = 1'b0;
        m_head = (m_head + 1) % DEPTH;
      end
      m_miss = dv && !occ_old[dt];
    end
  endtask

  task automatic idle(input int n, input bit dr, input int dt);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b0, dt, dr);
  endtask

  task automatic enq(input int t, input bit [7:0] d, input bit dr);
    step(1'b0, 1'b1, t, d, 1'b0, t, dr);
  endtask

  initial begin
    reset       = 1'b1;
    enq_valid   = 1'b0;
    enq_tag     = '0;
    enq_data    = '0;
    deq_valid   = 1'b0;
    deq_tag     = '0;
    drain_ready = 1'b0;

    // Reset for two cycles before any comparison: DUT state is unknown until
    // the first edge with reset high.
    repeat (2) @(posedge clk);
    model_reset();
    idle(1, 1'b0, 0);

    // Out-of-order fill, ordered drain with drain_ready held high.
    enq(2, 8'hA2, 1'b1);
    enq(0, 8'hA0, 1'b1);
    enq(3, 8'hA3, 1'b1);
    enq(1, 8'hA1, 1'b1);
    idle(5, 1'b1, 0);

    // Random-access lookup, release and miss pulse.
    enq(1, 8'h55, 1'b0);
    idle(1, 1'b0, 1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1, 1, 1'b0);
    idle(2, 1'b0, 1);

    // Fill all slots with the drain stalled, then try to overwrite slot 2.
    enq(0, 8'h10, 1'b0);
    enq(1, 8'h11, 1'b0);
    enq(2, 8'h12, 1'b0);
    enq(3, 8'h13, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2, 8'hFF, 1'b0, 2, 1'b0);

    // Empty the buffer so the head returns to slot 0.
    idle(5, 1'b1, 0);

    // Enqueue and deq racing on free slot 0; then deq and drain both on the
    // head slot.
    step(1'b0, 1'b1, 0, 8'h77, 1'b1, 0, 1'b0);
    idle(1, 1'b0, 0);
    enq(0, 8'h88, 1'b0);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b1);
    idle(2, 1'b0, 0);

    // Reset mid-operation with three entries held and head at slot 2.
    step(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
    enq(0, 8'h20, 1'b0);
    enq(1, 8'h21, 1'b0);
    idle(2, 1'b1, 0);
    enq(2, 8'h22, 1'b0);
    enq(3, 8'h23, 1'b0);
    enq(0, 8'h24, 1'b0);
    step(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
    idle(2, 1'b0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 250) == 0,
           1'($urandom % 2),
           int'($urandom % DEPTH),
           8'($urandom),
           ($urandom % 6) == 0,
           int'($urandom % DEPTH),
           ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
